// File: rtl/macc_pkg.sv
// Shared definitions for the MACC drain path: FSM states, default widths and a signed clamp.
package macc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } state_e;

  localparam int INTER_BITWIDTH_DEF   = 65;
  localparam int ACC_BITWIDTH_DEF     = 66;
  localparam int ACT_OUT_BITWIDTH_DEF = 16;
  localparam int DEPTH_DEF            = 16;
  localparam int PASS_W_DEF           = 8;
  localparam int SHIFT_W_DEF          = 7;

  // Working width for the clamp helper; callers sign-extend into it and cast the result back.
  localparam int SAT_W = 128;

  // Clamp x to the signed range of a w-bit value.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] x,
                                                         input int unsigned w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/macc_drain_if.sv
// Partial-sum input stream and quantized output stream of the MACC drain.
interface macc_drain_if #(
  parameter int INTER_BITWIDTH   = 65,
  parameter int ACT_OUT_BITWIDTH = 16
);
  logic                        psum_valid;
  logic                        psum_ready;
  logic [INTER_BITWIDTH-1:0]   psum_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACT_OUT_BITWIDTH-1:0] out_data;

  // Environment side: produces psums, consumes outputs.
  modport master (
    output psum_valid, psum_data, out_ready,
    input  psum_ready, out_valid, out_data
  );

  // Drain side.
  modport slave (
    input  psum_valid, psum_data, out_ready,
    output psum_ready, out_valid, out_data
  );
endinterface

// File: rtl/macc_drain_quant.sv
// Requantizer: arithmetic shift, optional ReLU (MACC_DRAIN_RELU_EN), saturate to output width.
module macc_drain_quant
  import macc_pkg::*;
#(
  parameter int ACC_BITWIDTH     = ACC_BITWIDTH_DEF,
  parameter int ACT_OUT_BITWIDTH = ACT_OUT_BITWIDTH_DEF,
  parameter int SHIFT_W          = SHIFT_W_DEF
) (
  input  logic signed [ACC_BITWIDTH-1:0]     acc_i,
  input  logic        [SHIFT_W-1:0]          shift_i,
  output logic signed [ACT_OUT_BITWIDTH-1:0] q_o
);

  logic signed [ACC_BITWIDTH-1:0] shifted;
  logic signed [SAT_W-1:0]        wide;

  always_comb begin
    // Oversized shifts collapse to pure sign fill.
    if (int'(shift_i) >= ACC_BITWIDTH) begin
      shifted = {ACC_BITWIDTH{acc_i[ACC_BITWIDTH-1]}};
    end else begin
      shifted = acc_i >>> shift_i;
    end
`ifdef MACC_DRAIN_RELU_EN
    if (shifted[ACC_BITWIDTH-1]) begin
      shifted = '0;
    end
`endif
    wide = {{(SAT_W-ACC_BITWIDTH){shifted[ACC_BITWIDTH-1]}}, shifted};
    q_o  = ACT_OUT_BITWIDTH'(sat_signed(wide, ACT_OUT_BITWIDTH));
  end

endmodule

// File: rtl/macc_drain.sv
// Accumulates PE-column partial sums over K-passes, then requantizes and streams the tile out.
// Build option MACC_DRAIN_RELU_EN enables ReLU inside macc_drain_quant.
module macc_drain
  import macc_pkg::*;
#(
  parameter int INTER_BITWIDTH   = INTER_BITWIDTH_DEF,
  parameter int ACC_BITWIDTH     = ACC_BITWIDTH_DEF,
  parameter int ACT_OUT_BITWIDTH = ACT_OUT_BITWIDTH_DEF,
  parameter int DEPTH            = DEPTH_DEF,
  parameter int ADDR_W           = $clog2(DEPTH),
  parameter int PASS_W           = PASS_W_DEF,
  parameter int SHIFT_W          = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    cfg_num_pos,
  input  logic [PASS_W-1:0]  cfg_num_pass,
  input  logic [SHIFT_W-1:0] cfg_shift,
  macc_drain_if.slave        bus,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W:0]   PosOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   PosMax  = (ADDR_W+1)'(DEPTH);
  localparam logic [PASS_W-1:0] PassOne = PASS_W'(1);

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             pos_q, pos_d;
  logic [PASS_W-1:0]             pass_q, pass_d;
  logic [ADDR_W:0]               rd_q, rd_d;
  logic [ADDR_W:0]               num_pos_q, num_pos_d;
  logic [PASS_W-1:0]             num_pass_q, num_pass_d;
  logic [SHIFT_W-1:0]            shift_q, shift_d;
  logic                          out_valid_q, out_valid_d;
  logic [ACT_OUT_BITWIDTH-1:0]   out_data_q, out_data_d;
  logic                          done_q, done_d;

  logic signed [ACC_BITWIDTH-1:0] acc_mem_q [DEPTH];
  logic                           mem_we;
  logic signed [ACC_BITWIDTH-1:0] mem_wdata;

  logic signed [ACC_BITWIDTH-1:0]     psum_ext;
  logic signed [ACC_BITWIDTH-1:0]     acc_rd;
  logic signed [ACC_BITWIDTH:0]       acc_sum;
  logic signed [SAT_W-1:0]            acc_wide;
  logic signed [ACC_BITWIDTH-1:0]     acc_sat;
  logic signed [ACC_BITWIDTH-1:0]     drain_rd;
  logic signed [ACT_OUT_BITWIDTH-1:0] quant_out;
  logic                               last_pos;
  logic                               last_pass;

  // Accumulate path: one extra bit of headroom, then clamp back to buffer width.
  assign psum_ext = {{(ACC_BITWIDTH-INTER_BITWIDTH){bus.psum_data[INTER_BITWIDTH-1]}},
                     bus.psum_data};
  assign acc_rd   = acc_mem_q[pos_q];
  assign acc_sum  = {acc_rd[ACC_BITWIDTH-1], acc_rd} + {psum_ext[ACC_BITWIDTH-1], psum_ext};
  assign acc_wide = {{(SAT_W-ACC_BITWIDTH-1){acc_sum[ACC_BITWIDTH]}}, acc_sum};
  assign acc_sat  = ACC_BITWIDTH'(sat_signed(acc_wide, ACC_BITWIDTH));
  assign drain_rd = acc_mem_q[rd_q[ADDR_W-1:0]];

  assign last_pos  = ({1'b0, pos_q} == (num_pos_q - PosOne));
  assign last_pass = (pass_q == (num_pass_q - PassOne));

  macc_drain_quant #(
    .ACC_BITWIDTH     (ACC_BITWIDTH),
    .ACT_OUT_BITWIDTH (ACT_OUT_BITWIDTH),
    .SHIFT_W          (SHIFT_W)
  ) u_quant (
    .acc_i   (drain_rd),
    .shift_i (shift_q),
    .q_o     (quant_out)
  );

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    pass_d      = pass_q;
    rd_d        = rd_q;
    num_pos_d   = num_pos_q;
    num_pass_d  = num_pass_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = (pass_q == '0) ? psum_ext : acc_sat;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          pos_d   = '0;
          pass_d  = '0;
          rd_d    = '0;
          shift_d = cfg_shift;
          if (cfg_num_pos == '0) begin
            num_pos_d = PosOne;
          end else if (cfg_num_pos > PosMax) begin
            num_pos_d = PosMax;
          end else begin
            num_pos_d = cfg_num_pos;
          end
          num_pass_d = (cfg_num_pass == '0) ? PassOne : cfg_num_pass;
        end
      end
      StAccum: begin
        if (bus.psum_valid) begin
          mem_we = 1'b1;
          if (last_pos) begin
            pos_d  = '0;
            pass_d = pass_q + 1'b1;
            if (last_pass) begin
              state_d = StDrain;
              rd_d    = '0;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        // Output register refills whenever it is empty or being consumed.
        if ((rd_q < num_pos_q) && (!out_valid_q || bus.out_ready)) begin
          out_valid_d = 1'b1;
          out_data_d  = quant_out;
          rd_d        = rd_q + PosOne;
        end else if (out_valid_q && bus.out_ready && (rd_q == num_pos_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      pass_q      <= '0;
      rd_q        <= '0;
      num_pos_q   <= PosOne;
      num_pass_q  <= PassOne;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pass_q      <= pass_d;
      rd_q        <= rd_d;
      num_pos_q   <= num_pos_d;
      num_pass_q  <= num_pass_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Buffer is left unreset; pass 0 always overwrites before any read-modify-write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      acc_mem_q[pos_q] <= mem_wdata;
    end
  end

  assign bus.psum_ready = (state_q == StAccum);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

endmodule

// File: tb/tb_macc_drain.sv
// Self-checking bench for macc_drain: scoreboard of expected outputs per tile.
module tb_macc_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] cfg_num_pos;
  logic [7:0] cfg_num_pass;
  logic [6:0] cfg_shift;
  logic       busy;
  logic       done;

  macc_drain_if #(.INTER_BITWIDTH(65), .ACT_OUT_BITWIDTH(16)) bus ();

  macc_drain dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_num_pos  (cfg_num_pos),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam logic signed [64:0] PsumMax = {1'b0, {64{1'b1}}};
  localparam logic signed [64:0] PsumMin = {1'b1, 64'b0};

  int checks = 0;
  int errors = 0;

  logic signed [64:0] psum_q [$];
  logic signed [15:0] exp_q  [$];
  logic signed [15:0] got_q  [$];

  logic send_ok;
  logic ready_at_start, ready_after_start;
  int   first_valid_cyc;
  logic stall_changed, early_done;
  logic done_after, busy_after, done_next;

  function automatic logic signed [15:0] act(input int v);
`ifdef MACC_DRAIN_RELU_EN
    if (v < 0) return '0;
`endif
    return 16'(v);
  endfunction

  task automatic start_tile(input int np, input int npass, input int sh);
    cfg_num_pos  = 5'(np);
    cfg_num_pass = 8'(npass);
    cfg_shift    = 7'(sh);
    start        = 1'b1;
    @(negedge clk);
    ready_at_start = bus.psum_ready;
    @(posedge clk); #1;
    start = 1'b0;
    ready_after_start = bus.psum_ready;
  endtask

  // Drives psum_q in order; optionally pulses start alongside item poke_at.
  task automatic send_psums(input int poke_at);
    int i   = 0;
    int cyc = 0;
    while (psum_q.size() > 0 && cyc < 500) begin
      bus.psum_valid = 1'b1;
      bus.psum_data  = psum_q[0];
      start          = (i == poke_at);
      if (start) cfg_num_pos = 5'd1;
      @(negedge clk);
      if (bus.psum_ready) begin
        void'(psum_q.pop_front());
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.psum_valid = 1'b0;
    start          = 1'b0;
    send_ok        = (psum_q.size() == 0);
    psum_q.delete();
  endtask

  // Captures n outputs into got_q; holds out_ready low stall_len cycles after stall_at outputs.
  task automatic collect(input int n, input int stall_at, input int stall_len);
    int got   = 0;
    int cyc   = 0;
    int stall = 0;
    logic [15:0] held = '0;
    first_valid_cyc = -1;
    stall_changed   = 1'b0;
    early_done      = 1'b0;
    while (got < n && cyc < 500) begin
      bus.out_ready = !(got == stall_at && stall < stall_len);
      @(negedge clk);
      if (done) early_done = 1'b1;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!bus.out_ready) begin
        if (stall == 0) held = bus.out_data;
        else if (bus.out_data !== held) stall_changed = 1'b1;
        stall++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready got %b want 0", bus.psum_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int vals [4] = '{1, 2, -3, 4};
    foreach (vals[k]) begin
      psum_q.push_back(65'(vals[k]));
      exp_q.push_back(act(vals[k]));
    end
    start_tile(4, 1, 0);
    checks++; if (ready_at_start !== 1'b0) begin errors++; $display("FAIL basic_ready_in_start_cycle got %b want 0", ready_at_start); end
    checks++; if (ready_after_start !== 1'b1) begin errors++; $display("FAIL basic_ready_after_start got %b want 1", ready_after_start); end
    send_psums(-1);
    collect(4, -1, 0);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (first_valid_cyc != 1) begin errors++; $display("FAIL basic_first_valid_latency got %0d want 1", first_valid_cyc); end
    checks++; if (early_done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b want 0", early_done); end
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done_after); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy_after); end
    checks++; if (done_next !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done_next); end
  endtask

  task automatic test_multipass();
    repeat (3) begin
      psum_q.push_back(65'(10));
      psum_q.push_back(65'(-5));
    end
    exp_q.push_back(act(15));
    exp_q.push_back(act(-8));
    start_tile(2, 3, 1);
    send_psums(-1);
    collect(2, -1, 0);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL multipass_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL multipass_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL multipass_done got %b want 1", done_after); end
  endtask

  // Output saturation plus accumulator clamp across three same-position passes.
  task automatic test_saturation();
    psum_q.push_back(65'(40000));
    psum_q.push_back(65'(-40000));
    exp_q.push_back(act(32767));
    exp_q.push_back(act(-32768));
    start_tile(2, 1, 0);
    send_psums(-1);
    collect(2, -1, 0);
    repeat (3) psum_q.push_back(PsumMax);
    exp_q.push_back(act(32767));
    start_tile(1, 3, 50);
    send_psums(-1);
    collect(1, -1, 0);
    repeat (3) psum_q.push_back(PsumMin);
    exp_q.push_back(act(-32768));
    start_tile(1, 3, 50);
    send_psums(-1);
    collect(1, -1, 0);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL sat_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  // cfg_num_pos 0 and >DEPTH, cfg_num_pass 0, shift beyond accumulator width.
  task automatic test_cfg_bounds();
    psum_q.push_back(65'(-5));
    exp_q.push_back(act(-1));
    start_tile(0, 0, 100);
    send_psums(-1);
    collect(1, -1, 0);
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL bounds_single_done got %b want 1", done_after); end
    psum_q.push_back(65'(5));
    exp_q.push_back(act(0));
    start_tile(1, 1, 100);
    send_psums(-1);
    collect(1, -1, 0);
    for (int k = 0; k < 16; k++) begin
      psum_q.push_back(65'(k * 3 - 20));
      exp_q.push_back(act(k * 3 - 20));
    end
    start_tile(20, 1, 0);
    send_psums(-1);
    collect(16, -1, 0);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL bounds_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bounds_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL bounds_clamped_done got %b want 1", done_after); end
  endtask

  task automatic test_backpressure();
    int vals [6] = '{7, -8, 9, -10, 11, -12};
    foreach (vals[k]) begin
      psum_q.push_back(65'(vals[k]));
      exp_q.push_back(act(vals[k]));
    end
    start_tile(6, 1, 0);
    send_psums(3);
    collect(6, 2, 3);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (stall_changed !== 1'b0) begin errors++; $display("FAIL bp_data_stable got %b want 0", stall_changed); end
    checks++; if (early_done !== 1'b0) begin errors++; $display("FAIL bp_early_done got %b want 0", early_done); end
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done_after); end
  endtask

  task automatic test_reset_mid();
    psum_q.push_back(65'(50));
    psum_q.push_back(65'(60));
    start_tile(4, 1, 0);
    send_psums(-1);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (bus.psum_ready !== 1'b0) begin errors++; $display("FAIL rstmid_psum_ready got %b want 0", bus.psum_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL rstmid_out_data got %h want 0", bus.out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    reset = 1'b0;
    @(posedge clk); #1;
    psum_q.push_back(65'(100));
    psum_q.push_back(65'(-100));
    psum_q.push_back(65'(7));
    exp_q.push_back(act(25));
    exp_q.push_back(act(-25));
    exp_q.push_back(act(1));
    start_tile(3, 1, 2);
    send_psums(-1);
    collect(3, -1, 0);
    checks++; if (!send_ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic signed [15:0] e = exp_q.pop_front();
      logic signed [15:0] g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rstmid_data got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL rstmid_done_after got %b want 1", done_after); end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    cfg_num_pos    = '0;
    cfg_num_pass   = '0;
    cfg_shift      = '0;
    bus.psum_valid = 1'b0;
    bus.psum_data  = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_multipass();
    test_saturation();
    test_cfg_bounds();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
